// File: rtl/conv_input_streamer.sv
// Streams one frame of IFM and weight words from host-loaded buffers to a
// convolution engine, then collects the engine's results and reports status.
module conv_input_streamer #(
  parameter int unsigned IFM_LEN  = 49,
  parameter int unsigned W_LEN    = 9,
  parameter int unsigned OFM_LEN  = 25,
  parameter int unsigned WAIT_MAX = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cfg_we,
  input  logic        cfg_sel,
  input  logic [5:0]  cfg_addr,
  input  logic [15:0] cfg_data,
  input  logic        start,
  input  logic        out_valid,
  input  logic [35:0] Out_OFM,
  output logic        in_valid,
  output logic        weight_valid,
  output logic [15:0] In_IFM_1,
  output logic [15:0] In_Weight_1,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [4:0]  ofm_count,
  output logic [40:0] ofm_sum
);

  localparam int unsigned IW = (IFM_LEN > 1) ? $clog2(IFM_LEN) : 1;
  localparam int unsigned WW = (W_LEN > 1) ? $clog2(W_LEN) : 1;
  localparam int unsigned KW = $clog2(IFM_LEN + 1);
  localparam int unsigned TW = $clog2(WAIT_MAX + 1);

  localparam logic [KW-1:0] K_END     = KW'(IFM_LEN);
  localparam logic [KW-1:0] K_WLEN    = KW'(W_LEN);
  localparam logic [6:0]    IFM_LIM   = 7'(IFM_LEN);
  localparam logic [6:0]    W_LIM     = 7'(W_LEN);
  localparam logic [4:0]    OFM_END   = 5'(OFM_LEN);
  localparam logic [TW-1:0] WAIT_LAST = TW'(WAIT_MAX - 1);

  typedef enum logic [2:0] {
    StIdle,
    StSend,
    StWait,
    StRecv,
    StDone
  } state_e;

  state_e          state;
  logic [KW-1:0]   k;
  logic [TW-1:0]   wait_cnt;
  logic [15:0]     ifm_buf [IFM_LEN];
  logic [15:0]     w_buf   [W_LEN];

  logic            ifm_wr_ok;
  logic            w_wr_ok;
  logic [40:0]     ofm_ext;

  // Full-width range check so out-of-range addresses never alias via truncation.
  always_comb begin
    ifm_wr_ok = ({1'b0, cfg_addr} < IFM_LIM);
    w_wr_ok   = ({1'b0, cfg_addr} < W_LIM);
    ofm_ext   = {5'b0, Out_OFM};
  end

  assign busy = (state != StIdle);

  // Host buffer writes, accepted only while idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < IFM_LEN; i++) ifm_buf[i] <= '0;
      for (int unsigned j = 0; j < W_LEN; j++) w_buf[j] <= '0;
    end else if (state == StIdle && cfg_we) begin
      if (!cfg_sel && ifm_wr_ok) ifm_buf[cfg_addr[IW-1:0]] <= cfg_data;
      if (cfg_sel && w_wr_ok)    w_buf[cfg_addr[WW-1:0]]   <= cfg_data;
    end
  end

  // Frame sequencer with registered stream outputs and result accumulation.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= StIdle;
      k            <= '0;
      wait_cnt     <= '0;
      in_valid     <= 1'b0;
      weight_valid <= 1'b0;
      In_IFM_1     <= '0;
      In_Weight_1  <= '0;
      done         <= 1'b0;
      err          <= 1'b0;
      ofm_count    <= '0;
      ofm_sum      <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        StIdle: begin
          // A simultaneous write wins over start.
          if (start && !cfg_we) begin
            state        <= StSend;
            err          <= 1'b0;
            ofm_count    <= '0;
            ofm_sum      <= '0;
            in_valid     <= 1'b1;
            In_IFM_1     <= ifm_buf[0];
            weight_valid <= 1'b1;
            In_Weight_1  <= w_buf[0];
            k            <= KW'(1);
          end
        end
        StSend: begin
          if (k == K_END) begin
            state        <= StWait;
            in_valid     <= 1'b0;
            weight_valid <= 1'b0;
            In_IFM_1     <= '0;
            In_Weight_1  <= '0;
            wait_cnt     <= '0;
          end else begin
            In_IFM_1 <= ifm_buf[k[IW-1:0]];
            if (k < K_WLEN) begin
              weight_valid <= 1'b1;
              In_Weight_1  <= w_buf[k[WW-1:0]];
            end else begin
              weight_valid <= 1'b0;
              In_Weight_1  <= '0;
            end
            k <= k + KW'(1);
          end
        end
        StWait: begin
          if (out_valid) begin
            ofm_count <= 5'd1;
            ofm_sum   <= ofm_ext;
            if (OFM_END == 5'd1) begin
              state <= StDone;
              done  <= 1'b1;
            end else begin
              state <= StRecv;
            end
          end else if (wait_cnt == WAIT_LAST) begin
            state <= StDone;
            err   <= 1'b1;
            done  <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + TW'(1);
          end
        end
        StRecv: begin
          if (out_valid) begin
            ofm_count <= ofm_count + 5'd1;
            ofm_sum   <= ofm_sum + ofm_ext;
            if (ofm_count + 5'd1 == OFM_END) begin
              state <= StDone;
              done  <= 1'b1;
            end
          end else begin
            // Burst ended early: keep the partial count and flag it.
            state <= StDone;
            err   <= 1'b1;
            done  <= 1'b1;
          end
        end
        StDone: begin
          state <= StIdle;
        end
        default: begin
          state <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_conv_input_streamer.sv
// Scoreboard bench for conv_input_streamer: stimulus pushes expected beats and
// frame results into queues, a negedge monitor pops and compares them.
module tb_conv_input_streamer;

  localparam int IFM_LEN  = 49;
  localparam int W_LEN    = 9;
  localparam int OFM_LEN  = 25;
  localparam int WAIT_MAX = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_we = 1'b0;
  logic        cfg_sel = 1'b0;
  logic [5:0]  cfg_addr = '0;
  logic [15:0] cfg_data = '0;
  logic        start = 1'b0;
  logic        out_valid = 1'b0;
  logic [35:0] Out_OFM = '0;
  logic        in_valid;
  logic        weight_valid;
  logic [15:0] In_IFM_1;
  logic [15:0] In_Weight_1;
  logic        busy;
  logic        done;
  logic        err;
  logic [4:0]  ofm_count;
  logic [40:0] ofm_sum;

  conv_input_streamer #(
    .IFM_LEN (IFM_LEN),
    .W_LEN   (W_LEN),
    .OFM_LEN (OFM_LEN),
    .WAIT_MAX(WAIT_MAX)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cfg_we      (cfg_we),
    .cfg_sel     (cfg_sel),
    .cfg_addr    (cfg_addr),
    .cfg_data    (cfg_data),
    .start       (start),
    .out_valid   (out_valid),
    .Out_OFM     (Out_OFM),
    .in_valid    (in_valid),
    .weight_valid(weight_valid),
    .In_IFM_1    (In_IFM_1),
    .In_Weight_1 (In_Weight_1),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .ofm_count   (ofm_count),
    .ofm_sum     (ofm_sum)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic        err;
    logic [4:0]  cnt;
    logic [40:0] sum;
    int          gap;  // cycles from WAIT entry to done, -1 = don't care
  } res_t;

  logic [15:0] exp_ifm[$];
  logic [15:0] exp_w[$];
  int          exp_run[$];
  res_t        exp_res[$];

  logic [15:0] m_ifm [IFM_LEN];
  logic [15:0] m_w   [W_LEN];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic flag(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: output seen with nothing expected", name);
  endtask

  // Monitor: compares every presented beat and done pulse against the queues.
  initial begin
    int   run;
    int   since;
    logic prev_iv;
    res_t r;
    run     = 0;
    since   = 0;
    prev_iv = 1'b0;
    forever begin
      @(negedge clk);
      if (in_valid === 1'b1) begin
        if (exp_ifm.size() == 0) flag("ifm beat");
        else check("ifm beat", In_IFM_1, exp_ifm.pop_front());
        check("weight_valid position", weight_valid, run < W_LEN);
        if (weight_valid === 1'b1) begin
          if (exp_w.size() == 0) flag("weight beat");
          else check("weight beat", In_Weight_1, exp_w.pop_front());
        end else begin
          check("weight data when not valid", In_Weight_1, 0);
        end
        run++;
      end else begin
        check("stream outputs idle", {weight_valid, In_IFM_1, In_Weight_1}, 0);
        if (prev_iv) begin
          if (exp_run.size() == 0) flag("in_valid run");
          else check("in_valid run length", run, exp_run.pop_front());
          run   = 0;
          since = 0;
        end else begin
          since++;
        end
      end
      prev_iv = in_valid;
      if (done === 1'b1) begin
        if (exp_res.size() == 0) begin
          flag("done pulse");
        end else begin
          r = exp_res.pop_front();
          check("done err", err, r.err);
          check("done ofm_count", ofm_count, r.cnt);
          check("done ofm_sum", ofm_sum, r.sum);
          if (r.gap >= 0) check("done latency after WAIT", since, r.gap);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic sel, input logic [5:0] addr, input logic [15:0] data);
    cfg_we   = 1'b1;
    cfg_sel  = sel;
    cfg_addr = addr;
    cfg_data = data;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic push_frame(input int nbeats);
    for (int i = 0; i < nbeats; i++) exp_ifm.push_back(m_ifm[i]);
    for (int j = 0; j < W_LEN && j < nbeats; j++) exp_w.push_back(m_w[j]);
    exp_run.push_back(nbeats);
  endtask

  task automatic wait_send_end();
    int c;
    c = 0;
    while (in_valid === 1'b1 && c < 100) begin
      tick();
      c++;
    end
    check("SEND finished within bound", in_valid, 0);
  endtask

  task automatic wait_idle();
    int c;
    c = 0;
    while (busy === 1'b1 && c < 200) begin
      tick();
      c++;
    end
    check("frame back to IDLE within bound", busy, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [35:0] vals [10];

    // Reset state
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check("reset in_valid", in_valid, 0);
    check("reset weight_valid", weight_valid, 0);
    check("reset In_IFM_1", In_IFM_1, 0);
    check("reset In_Weight_1", In_Weight_1, 0);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset err", err, 0);
    check("reset ofm_count", ofm_count, 0);
    check("reset ofm_sum", ofm_sum, 0);

    // Load buffers: IFM[i] = i+1, W[j] = 1
    for (int i = 0; i < IFM_LEN; i++) begin
      wr(1'b0, 6'(i), 16'(i + 1));
      m_ifm[i] = 16'(i + 1);
    end
    for (int j = 0; j < W_LEN; j++) begin
      wr(1'b1, 6'(j), 16'd1);
      m_w[j] = 16'd1;
    end
    // Out-of-range writes must not land anywhere
    wr(1'b1, 6'd9, 16'hBEEF);
    wr(1'b1, 6'd16, 16'hBEEF);
    wr(1'b0, 6'd49, 16'hBEEF);
    wr(1'b0, 6'd63, 16'hBEEF);

    // Write and start together: write lands, start ignored
    cfg_we   = 1'b1;
    cfg_sel  = 1'b0;
    cfg_addr = 6'd5;
    cfg_data = 16'h0055;
    start    = 1'b1;
    tick();
    cfg_we = 1'b0;
    start  = 1'b0;
    m_ifm[5] = 16'h0055;
    check("start ignored with cfg_we", busy, 0);

    // Frame 1: full burst of 25 x 100, two trailing beats ignored
    push_frame(IFM_LEN);
    exp_res.push_back('{1'b0, 5'd25, 41'd2500, -1});
    pulse_start();
    wait_send_end();
    out_valid = 1'b1;
    Out_OFM   = 36'd100;
    repeat (27) tick();
    out_valid = 1'b0;
    wait_idle();
    tick();
    tick();
    check("held err after full frame", err, 0);
    check("held ofm_count after full frame", ofm_count, 25);
    check("held ofm_sum after full frame", ofm_sum, 2500);

    // Frame 2: start and write during SEND are ignored; then WAIT times out
    push_frame(IFM_LEN);
    exp_res.push_back('{1'b1, 5'd0, 41'd0, WAIT_MAX});
    pulse_start();
    cfg_we   = 1'b1;
    cfg_sel  = 1'b0;
    cfg_addr = 6'd3;
    cfg_data = 16'hDEAD;
    start    = 1'b1;
    tick();
    cfg_we = 1'b0;
    start  = 1'b0;
    wait_send_end();
    wait_idle();
    tick();
    check("held err after timeout", err, 1);
    check("held ofm_count after timeout", ofm_count, 0);

    // Frame 3: late first result, 10 beats then drop
    vals[0] = 36'hF_FFFF_FFFF;
    for (int i = 1; i < 10; i++) vals[i] = 36'(i);
    push_frame(IFM_LEN);
    exp_res.push_back('{1'b1, 5'd10, 41'd68719476780, -1});
    pulse_start();
    wait_send_end();
    repeat (5) tick();
    for (int i = 0; i < 10; i++) begin
      out_valid = 1'b1;
      Out_OFM   = vals[i];
      tick();
    end
    out_valid = 1'b0;
    Out_OFM   = '0;
    wait_idle();
    tick();
    check("held err after short burst", err, 1);
    check("held ofm_count after short burst", ofm_count, 10);

    // Frame 4: reset at SEND beat 20 aborts without a done pulse
    push_frame(21);
    pulse_start();
    repeat (20) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort in_valid", in_valid, 0);
    check("abort busy", busy, 0);
    check("abort done", done, 0);
    check("abort ofm_count", ofm_count, 0);
    for (int i = 0; i < IFM_LEN; i++) m_ifm[i] = '0;
    for (int j = 0; j < W_LEN; j++) m_w[j] = '0;

    // Frame 5: buffers stream back as zero after reset
    push_frame(IFM_LEN);
    exp_res.push_back('{1'b0, 5'd25, 41'd175, -1});
    pulse_start();
    wait_send_end();
    out_valid = 1'b1;
    Out_OFM   = 36'd7;
    repeat (25) tick();
    out_valid = 1'b0;
    wait_idle();
    repeat (5) tick();

    check("ifm queue drained", exp_ifm.size(), 0);
    check("weight queue drained", exp_w.size(), 0);
    check("run queue drained", exp_run.size(), 0);
    check("result queue drained", exp_res.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/conv_input_streamer.md
CONV_INPUT_STREAMER -- requirements
Module: conv_input_streamer

Interface
REQ-001 Parameter IFM_LEN, 49, number of IFM words streamed per frame (7x7).
REQ-002 Parameter W_LEN, 9, number of weight words streamed per frame (3x3).
REQ-003 Parameter OFM_LEN, 25, number of OFM results expected back (5x5).
REQ-004 Parameter WAIT_MAX, 64, idle cycles tolerated before first out_valid.
REQ-005 clk  in  1  single clock; all logic on rising edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 cfg_we  in  1  host buffer write strobe.
REQ-008 cfg_sel  in  1  write target: 0 = IFM buffer, 1 = weight buffer.
REQ-009 cfg_addr  in  6  write address.
REQ-010 cfg_data  in  16  write data.
REQ-011 start  in  1  one-cycle request to stream one frame.
REQ-012 out_valid  in  1  result-valid strobe from the convolution engine.
REQ-013 Out_OFM  in  36  result word from the convolution engine.
REQ-014 in_valid  out  1  IFM-valid strobe to the engine, registered.
REQ-015 weight_valid  out  1  weight-valid strobe to the engine, registered.
REQ-016 In_IFM_1  out  16  IFM word to the engine, registered.
REQ-017 In_Weight_1  out  16  weight word to the engine, registered.
REQ-018 busy  out  1  high in every state except IDLE.
REQ-019 done  out  1  one-cycle pulse at frame end.
REQ-020 err  out  1  frame-end status: 1 = timeout or short burst; held until next start.
REQ-021 ofm_count  out  5  results received this frame; held until next start.
REQ-022 ofm_sum  out  41  unsigned sum of received Out_OFM values; held until next start.

Function
REQ-023 Buffers: IFM_LEN x 16 and W_LEN x 16 registers, written on cfg_we in IDLE only; cfg_we in any other state is ignored.
REQ-024 Writes with cfg_addr >= IFM_LEN (cfg_sel = 0) or >= W_LEN (cfg_sel = 1) are ignored.
REQ-025 FSM states: IDLE, SEND, WAIT, RECV, DONE.
REQ-026 IDLE -> SEND when start = 1 and cfg_we = 0; if both are high, the write is performed and start is ignored.
REQ-027 On the accepted start, err, ofm_count and ofm_sum clear to 0 and index k = 0.
REQ-028 In SEND, beat k (0..IFM_LEN-1) drives in_valid = 1, In_IFM_1 = IFM[k]; beat 0 appears on the cycle after start is sampled.
REQ-029 On beats k < W_LEN, weight_valid = 1 and In_Weight_1 = W[k]; otherwise weight_valid = 0 and In_Weight_1 = 0.
REQ-030 After beat IFM_LEN-1, go to WAIT; in_valid, weight_valid and both data outputs are 0 in every state other than SEND.
REQ-031 WAIT: out_valid = 1 -> RECV, and that cycle counts as result 1.
REQ-032 WAIT: WAIT_MAX consecutive cycles without out_valid -> DONE with err = 1.
REQ-033 RECV: each cycle with out_valid = 1 increments ofm_count and adds zero-extended Out_OFM to ofm_sum.
REQ-034 RECV: on result OFM_LEN, go to DONE with err = 0; out_valid beats after that are ignored.
REQ-035 RECV: out_valid = 0 before OFM_LEN results -> DONE with err = 1; the count so far is kept.
REQ-036 DONE lasts one cycle with done = 1, then returns to IDLE.
REQ-037 start in any state other than IDLE is ignored.
REQ-038 out_valid in IDLE or SEND is ignored.
REQ-039 ofm_sum cannot overflow: 25 x (2^36 - 1) < 2^41.

Reset
REQ-040 While rst = 1, at the clock edge: state = IDLE, both buffers = 0, and every output = 0 (in_valid, weight_valid, In_IFM_1, In_Weight_1, busy, done, err, ofm_count, ofm_sum).
REQ-041 rst asserted mid-frame aborts the frame immediately; no done pulse is produced.

Verification
REQ-042 Load IFM[i] = i+1 and W[j] = 1, pulse start -> in_valid high for 49 consecutive cycles carrying 1..49; weight_valid high for the first 9 of those cycles only, carrying 1.
REQ-043 After SEND, drive 25 out_valid beats with Out_OFM = 100 -> done pulse, err = 0, ofm_count = 25, ofm_sum = 2500.
REQ-044 Never assert out_valid -> done exactly 64 cycles after entering WAIT, err = 1, ofm_count = 0.
REQ-045 Assert out_valid for 10 beats, then drop it -> done, err = 1, ofm_count = 10.
REQ-046 Pulse start and write cfg_addr = 3 during SEND -> both ignored; the streamed IFM[3] equals the value loaded before start.
REQ-047 Assert rst at SEND beat 20 -> next cycle in_valid = 0, busy = 0, buffers read back 0, no done pulse.
